uart_tx_block: RTL and testbench

Serial transmitter for the UART link; the transmit-side counterpart of the receive block. It accepts a parallel byte on a single-cycle start request, frames it as start bit, data bits LSB-first and stop bit, and drives the serial line with each bit held for a fixed number of clocks. It sits between the host-side data source and the off-chip serial line, which idles high.

---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/flex_pts_sr.sv | 44 ++++
 rtl/uart_tx_block.sv | 141 ++++++++++++++
 tb/tb_uart_tx_block.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART transmit definitions: FSM state encoding and default frame geometry.
// The defaults are shared with the receive side, so both ends agree on the frame format.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int DEFAULT_DATA_BITS  = 8;
   localparam int DEFAULT_BIT_PERIOD = 10;

   // Clocks of tx_busy per frame: start bit, data bits and stop bit.
   function automatic int frame_cycles(input int data_bits, input int bit_period);
      return (data_bits + 2) * bit_period;
   endfunction

endpackage

// File: rtl/flex_pts_sr.sv
// Parallel-to-serial shift register, ones-filled. Output is the bit at the shifting end.
// Latency: loads or shifts on the enabling edge. No backpressure; load wins over shift.
module flex_pts_sr
   import uart_tx_pkg::*;
#(
   parameter int NUM_BITS  = DEFAULT_DATA_BITS,
   parameter bit SHIFT_MSB = 1'b0
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                load_enable,
   input  logic                shift_enable,
   input  logic [NUM_BITS-1:0] parallel_in,
   output logic                serial_out
);

   logic [NUM_BITS-1:0] sr_q;
   logic [NUM_BITS-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load_enable) begin
         sr_d = parallel_in;
      end else if (shift_enable) begin
         // Vacated positions fill with the idle line level.
         if (SHIFT_MSB) begin
            sr_d = {sr_q[NUM_BITS-2:0], 1'b1};
         end else begin
            sr_d = {1'b1, sr_q[NUM_BITS-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sr_q <= '1;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign serial_out = SHIFT_MSB ? sr_q[NUM_BITS-1] : sr_q[0];

endmodule

// File: rtl/uart_tx_block.sv
// UART transmitter: start bit, DATA_BITS data bits LSB-first, stop bit, each held BIT_PERIOD clocks.
// Latency: start bit appears the cycle after acceptance. tx_start is ignored while busy (no queueing).
module uart_tx_block
   import uart_tx_pkg::*;
#(
   parameter int DATA_BITS  = DEFAULT_DATA_BITS,
   parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 serial_out,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int TW = $clog2(BIT_PERIOD);
   localparam int IW = $clog2(DATA_BITS);

   localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_PERIOD - 1);
   localparam logic [IW-1:0] INDEX_LAST = IW'(DATA_BITS - 1);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_START = START;
   localparam logic [1:0] S_DATA  = DATA;
   localparam logic [1:0] S_STOP  = STOP;

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [IW-1:0] bit_idx_q, bit_idx_d;
   logic          serial_out_q, serial_out_d;
   logic          tx_busy_q, tx_busy_d;
   logic          tx_done_q, tx_done_d;

   logic          bit_end;
   logic          sr_load;
   logic          sr_shift;
   logic          sr_lsb;

   flex_pts_sr #(
      .NUM_BITS  (DATA_BITS),
      .SHIFT_MSB (1'b0)
   ) u_sr (
      .clk          (clk),
      .n_rst        (n_rst),
      .load_enable  (sr_load),
      .shift_enable (sr_shift),
      .parallel_in  (tx_data),
      .serial_out   (sr_lsb)
   );

   assign bit_end = (timer_q == TIMER_LAST);

   // The register shifts on every edge that enters a data bit; the bit being
   // entered is its LSB just before that shift, so it can be registered directly.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      sr_load   = 1'b0;
      sr_shift  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (tx_start) begin
               sr_load = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               bit_idx_d = '0;
               sr_shift  = 1'b1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == INDEX_LAST) begin
                  state_d   = S_STOP;
                  bit_idx_d = '0;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  sr_shift  = 1'b1;
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            bit_idx_d = '0;
         end
      endcase
   end

   always_comb begin
      timer_d = '0;
      if (state_q != S_IDLE) begin
         timer_d = bit_end ? '0 : timer_q + 1'b1;
      end
   end

   // Outputs are decoded from the next state so the registered line never glitches.
   always_comb begin
      serial_out_d = 1'b1;
      case (state_d)
         S_START: serial_out_d = 1'b0;
         S_DATA:  serial_out_d = sr_shift ? sr_lsb : serial_out_q;
         default: serial_out_d = 1'b1;
      endcase
      tx_busy_d = (state_d != S_IDLE);
      tx_done_d = (state_q == S_STOP) && (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         bit_idx_q    <= '0;
         serial_out_q <= 1'b1;
         tx_busy_q    <= 1'b0;
         tx_done_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         bit_idx_q    <= bit_idx_d;
         serial_out_q <= serial_out_d;
         tx_busy_q    <= tx_busy_d;
         tx_done_q    <= tx_done_d;
      end
   end

   assign serial_out = serial_out_q;
   assign tx_busy    = tx_busy_q;
   assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_uart_tx_block.sv
// Bench for uart_tx_block: default geometry (8 bits, 10 clocks) and a 5-bit/3-clock instance,
// with accepted frames queued as expected waveforms and a monitor comparing every cycle.
module tb_uart_tx_block;

   localparam int DB_A = 8;
   localparam int BP_A = 10;
   localparam int DB_B = 5;
   localparam int BP_B = 3;

   typedef struct {
      int         dut;
      logic [7:0] data;
      longint     start;
   } frame_t;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       tx_start_a = 1'b0;
   logic [7:0] tx_data_a = '0;
   logic       ser_a, busy_a, done_a;
   logic       tx_start_b = 1'b0;
   logic [4:0] tx_data_b = '0;
   logic       ser_b, busy_b, done_b;

   longint     cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   frame_t     exp_q[$];
   longint     last_start[2] = '{-1000000, -1000000};

   bit         in_frame[2] = '{0, 0};
   int         off[2] = '{0, 0};
   logic [7:0] cur_data[2] = '{8'h00, 8'h00};
   longint     done_at[2] = '{-1, -1};
   int         run[2] = '{0, 0};
   logic       bprev[2] = '{1'b0, 1'b0};

   uart_tx_block #(.DATA_BITS(DB_A), .BIT_PERIOD(BP_A)) dut_a (
      .clk        (clk),
      .n_rst      (n_rst),
      .tx_start   (tx_start_a),
      .tx_data    (tx_data_a),
      .serial_out (ser_a),
      .tx_busy    (busy_a),
      .tx_done    (done_a)
   );

   uart_tx_block #(.DATA_BITS(DB_B), .BIT_PERIOD(BP_B)) dut_b (
      .clk        (clk),
      .n_rst      (n_rst),
      .tx_start   (tx_start_b),
      .tx_data    (tx_data_b),
      .serial_out (ser_b),
      .tx_busy    (busy_b),
      .tx_done    (done_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int db_of(input int d);
      return (d == 0) ? DB_A : DB_B;
   endfunction

   function automatic int bp_of(input int d);
      return (d == 0) ? BP_A : BP_B;
   endfunction

   function automatic int len_of(input int d);
      return (db_of(d) + 2) * bp_of(d);
   endfunction

   // Line level at a given clock offset into a frame: start 0, data LSB-first, stop 1.
   function automatic logic exp_bit(input logic [7:0] data, input int o, input int d);
      int b;
      b = o / bp_of(d);
      if (b == 0) return 1'b0;
      if (b <= db_of(d)) return data[b-1];
      return 1'b1;
   endfunction

   function automatic int find_exp(input int d);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].dut == d) return i;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s dut%0d cyc=%0d actual=%0h required=%0h", name, d, cyc, act, req);
      end
   endtask

   // Monitor: pops the expected frame when the DUT raises tx_busy, then checks every cycle.
   always @(negedge clk) begin
      logic s, b, dn;
      int   idx;
      for (int d = 0; d < 2; d++) begin
         s  = (d == 0) ? ser_a  : ser_b;
         b  = (d == 0) ? busy_a : busy_b;
         dn = (d == 0) ? done_a : done_b;
         if (!n_rst) begin
            chk("rst_serial_out", d, 64'(s), 64'd1);
            chk("rst_tx_busy", d, 64'(b), 64'd0);
            chk("rst_tx_done", d, 64'(dn), 64'd0);
            in_frame[d] = 1'b0;
            done_at[d]  = -1;
            run[d]      = 0;
            bprev[d]    = 1'b0;
         end else begin
            idx = find_exp(d);
            if (!in_frame[d] && b) begin
               if (idx < 0) begin
                  chk("unexpected_frame_busy", d, 64'(b), 64'd0);
               end else begin
                  chk("frame_start_cycle", d, 64'(cyc), 64'(exp_q[idx].start));
                  cur_data[d] = exp_q[idx].data;
                  exp_q.delete(idx);
                  in_frame[d] = 1'b1;
                  off[d]      = 0;
               end
            end else if (!in_frame[d] && idx >= 0 && exp_q[idx].start < cyc) begin
               chk("frame_missing_busy", d, 64'(b), 64'd1);
               exp_q.delete(idx);
            end

            if (in_frame[d]) begin
               chk("serial_bit", d, 64'(s), 64'(exp_bit(cur_data[d], off[d], d)));
               chk("busy_in_frame", d, 64'(b), 64'd1);
               chk("done_in_frame", d, 64'(dn), 64'd0);
               off[d]++;
               if (off[d] == len_of(d)) begin
                  in_frame[d] = 1'b0;
                  done_at[d]  = cyc + 1;
               end
            end else begin
               chk("idle_serial_out", d, 64'(s), 64'd1);
               chk("idle_tx_busy", d, 64'(b), 64'd0);
               chk("tx_done", d, 64'(dn), 64'(cyc == done_at[d]));
            end

            if (b) run[d]++;
            if (bprev[d] && !b) begin
               chk("busy_length", d, 64'(run[d]), 64'(len_of(d)));
               run[d] = 0;
            end
            bprev[d] = b;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pulse tx_start for one cycle; the model accepts only if the previous frame has ended.
   task automatic send(input int d, input logic [7:0] data);
      frame_t f;
      if (d == 0) begin
         tx_data_a  = data;
         tx_start_a = 1'b1;
      end else begin
         tx_data_b  = data[4:0];
         tx_start_b = 1'b1;
      end
      if (cyc >= last_start[d] + len_of(d)) begin
         f.dut   = d;
         f.data  = data;
         f.start = cyc + 1;
         exp_q.push_back(f);
         last_start[d] = cyc + 1;
      end
      tick(1);
      tx_start_a = 1'b0;
      tx_start_b = 1'b0;
      tx_data_a  = 8'($urandom);
      tx_data_b  = 5'($urandom);
   endtask

   task automatic do_reset(input int n);
      n_rst = 1'b0;
      exp_q.delete();
      last_start[0] = -1000000;
      last_start[1] = -1000000;
      tick(n);
      n_rst = 1'b1;
   endtask

   initial begin
      n_rst = 1'b0;
      tick(3);
      n_rst = 1'b1;
      tick(4);

      send(0, 8'hA5);
      tick(len_of(0) + 5);

      // Retrigger with 0xFF during the fourth data bit of 0x3C.
      send(0, 8'h3C);
      tick(4 * BP_A + 4);
      send(0, 8'hFF);
      tick(len_of(0) + 20);

      send(0, 8'h00);
      while (cyc < last_start[0] + len_of(0)) tick(1);
      send(0, 8'hFF);
      tick(len_of(0) + 5);

      send(0, 8'h55);
      tick(4 * BP_A + 3);
      do_reset(2);
      tick(6);
      send(0, 8'h81);
      tick(len_of(0) + 5);

      send(1, 8'h13);
      tick(len_of(1) + 5);

      for (int i = 0; i < 40; i++) begin
         send(int'($urandom_range(0, 1)), 8'($urandom));
         tick(int'($urandom_range(0, 110)));
      end
      tick(len_of(0) + 20);

      chk("queue_drained", 0, 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
